// File: rtl/dmem_pkg.sv
// Shared constants and state type for the data memory.
package dmem_pkg;

  localparam int unsigned MEM_RD_BIT    = 1;
  localparam int unsigned MEM_WR_BIT    = 0;
  localparam int unsigned WORD_BYTES    = 4;
  localparam int unsigned BYTE_OFS_BITS = $clog2(WORD_BYTES);
  localparam int unsigned DATA_WIDTH    = 8 * WORD_BYTES;

  typedef enum logic {
    CLEAR,
    READY
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word storage: one combinational read port, one synchronous write port, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem.sv
// MEM-stage data memory: post-reset clear sequencer, legality check and error capture
// in front of a plain word array.
module data_mem
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            mem_ctrl_input,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  init_busy,
  output logic                  mem_err,
  output logic                  err_sticky,
  output logic [31:0]           err_addr
);

  dmem_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  aligned, in_range, active, legal, illegal;

  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;

  logic                  mem_err_q;
  logic                  err_sticky_q;
  logic [31:0]           err_addr_q;

  assign word_idx = address[BYTE_OFS_BITS +: ADDR_WIDTH];
  assign aligned  = (address[BYTE_OFS_BITS-1:0] == '0);
  // Any set bit above the word index points outside the array.
  assign in_range = ((address >> (ADDR_WIDTH + BYTE_OFS_BITS)) == '0);
  assign active   = (mem_ctrl_input != 2'b00);
  assign legal    = aligned && in_range && (state_q == READY);
  assign illegal  = active && !legal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : READY;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // The clear sequencer owns the write port while clearing; pipeline accesses are
  // illegal then, so the two never compete.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    arr_we    = 1'b0;
    arr_waddr = word_idx;
    arr_wdata = w_data;
    case (state_q)
      CLEAR: begin
        arr_we    = 1'b1;
        arr_waddr = clr_idx_q;
        arr_wdata = '0;
        clr_idx_d = clr_idx_q + ADDR_WIDTH'(1);
        if (clr_idx_q == '1) begin
          state_d = READY;
        end
      end
      READY: begin
        arr_we = legal && mem_ctrl_input[MEM_WR_BIT];
      end
      default: begin
        state_d = READY;
      end
    endcase
  end

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .raddr(word_idx),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      mem_err_q <= illegal;
      if (illegal && !err_sticky_q) begin
        err_sticky_q <= 1'b1;
        err_addr_q   <= address;
      end
    end
  end

  assign read_data  = (legal && mem_ctrl_input[MEM_RD_BIT]) ? arr_rdata : '0;
  assign init_busy  = (state_q == CLEAR);
  assign mem_err    = mem_err_q;
  assign err_sticky = err_sticky_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_data_mem.sv
// Randomised scoreboard bench for data_mem: stimulus pushes cycle-tagged expectations
// from an abstract memory model, a negedge monitor retires them.
module tb_data_mem;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  localparam int S_RD    = 0;
  localparam int S_ERR   = 1;
  localparam int S_STK   = 2;
  localparam int S_EADDR = 3;
  localparam int S_BUSY  = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  mem_ctrl_input;
  logic [31:0] address;
  logic [31:0] w_data;
  logic [31:0] read_data;
  logic        init_busy;
  logic        mem_err;
  logic        err_sticky;
  logic [31:0] err_addr;

  data_mem #(
    .ADDR_WIDTH    (AW),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_ctrl_input(mem_ctrl_input),
    .address       (address),
    .w_data        (w_data),
    .read_data     (read_data),
    .init_busy     (init_busy),
    .mem_err       (mem_err),
    .err_sticky    (err_sticky),
    .err_addr      (err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] want;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: what the memory holds, how many clear edges remain, error capture.
  logic [31:0] model_mem [DEPTH];
  int          busy_left;
  bit          in_reset;
  bit          m_sticky;
  logic [31:0] m_eaddr;

  task automatic push(input int c, input int s, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc  = c;
    e.sig  = s;
    e.want = v;
    e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!in_reset && busy_left > 0) busy_left--;
    push(cyc, S_BUSY, (busy_left != 0) ? 32'd1 : 32'd0, "init_busy");
  endtask

  task automatic access(input logic [1:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    bit          legal;
    bit          active;
    logic [31:0] exp_rd;
    step();
    mem_ctrl_input = ctrl;
    address        = addr;
    w_data         = wd;
    active = (ctrl != 2'b00);
    legal  = (addr[1:0] == 2'b00) && (addr < 32'(4 * DEPTH)) && (busy_left == 0);
    exp_rd = (legal && ctrl[1]) ? model_mem[addr[AW+1:2]] : 32'd0;
    push(cyc, S_RD, exp_rd, {tag, "/read_data"});
    if (legal && ctrl[0]) model_mem[addr[AW+1:2]] = wd;
    if (active && !legal && !m_sticky) begin
      m_sticky = 1'b1;
      m_eaddr  = addr;
    end
    push(cyc + 1, S_ERR, (active && !legal) ? 32'd1 : 32'd0, {tag, "/mem_err"});
    push(cyc + 1, S_STK, m_sticky ? 32'd1 : 32'd0, {tag, "/err_sticky"});
    push(cyc + 1, S_EADDR, m_eaddr, {tag, "/err_addr"});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) access(2'b00, 32'd0, 32'd0, "idle");
  endtask

  // Called with reset_n already low: hold two cycles, check reset values, release.
  task automatic hold_and_release();
    in_reset       = 1'b1;
    busy_left      = DEPTH;
    m_sticky       = 1'b0;
    m_eaddr        = 32'd0;
    mem_ctrl_input = 2'b00;
    address        = 32'd0;
    w_data         = 32'd0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    step();
    step();
    push(cyc, S_RD, 32'd0, "reset/read_data");
    push(cyc, S_ERR, 32'd0, "reset/mem_err");
    push(cyc, S_STK, 32'd0, "reset/err_sticky");
    push(cyc, S_EADDR, 32'd0, "reset/err_addr");
    reset_n  = 1'b1;
    in_reset = 1'b0;
  endtask

  task automatic do_reset();
    step();
    mem_ctrl_input = 2'b00;
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    hold_and_release();
  endtask

  always @(negedge clk) begin : monitor
    logic [31:0] act;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        case (exp_q[i].sig)
          S_RD:    act = read_data;
          S_ERR:   act = {31'd0, mem_err};
          S_STK:   act = {31'd0, err_sticky};
          S_EADDR: act = err_addr;
          default: act = {31'd0, init_busy};
        endcase
        checks++;
        if (act !== exp_q[i].want) begin
          errors++;
          $display("FAIL %s cycle %0d: got %h expected %h",
                   exp_q[i].name, cyc, act, exp_q[i].want);
        end
        exp_q.delete(i);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] a;
    logic [1:0]  c;
    int          r;
    reset_n = 1'b0;
    hold_and_release();

    // Full clear, then array reads back zero.
    idle(DEPTH);
    access(2'b10, 32'h00, 32'd0, "rd0_after_clear");

    access(2'b01, 32'h10, 32'hDEADBEEF, "wr_10");
    access(2'b10, 32'h10, 32'd0, "rd_10");
    access(2'b01, 32'h13, 32'h12345678, "wr_misaligned");
    access(2'b10, 32'h10, 32'd0, "rd_10_kept");
    access(2'b10, 32'h40, 32'd0, "rd_out_of_range");
    access(2'b10, 32'h04, 32'd0, "rd_04_old");
    access(2'b11, 32'h04, 32'h1, "rdwr_04");
    access(2'b10, 32'h04, 32'd0, "rd_04_new");
    access(2'b11, 32'h3C, 32'hA5A5A5A5, "rdwr_last");
    access(2'b10, 32'h3C, 32'd0, "rd_last");

    // Reset mid-clear: accesses during busy are dropped, reset lands at clear index 7.
    do_reset();
    access(2'b01, 32'h10, 32'hCAFEF00D, "wr_during_clear");
    access(2'b10, 32'h10, 32'd0, "rd_during_clear");
    access(2'b11, 32'h08, 32'h55, "rdwr_during_clear");
    idle(3);
    do_reset();
    idle(DEPTH);
    access(2'b10, 32'h10, 32'd0, "rd_10_recleared");
    access(2'b10, 32'h04, 32'd0, "rd_04_recleared");
    access(2'b10, 32'h3C, 32'd0, "rd_last_recleared");

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      c = 2'($urandom_range(0, 3));
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = $urandom() | 32'h40;
      access(c, a, $urandom(), "rand");
    end

    idle(2);
    step();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Word-addressed data memory that serves the load/store requests the MEM pipeline stage drives: 2-bit memory control, byte address, and store data. Reads are combinational so the MEM stage can register `read_data` at the same clock edge. Writes commit at the clock edge. After reset, a clear sequencer zeroes the whole array, because an asynchronous reset cannot clear a RAM. Illegal accesses are dropped and reported on registered error outputs.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: word-index width; depth is 2^ADDR_WIDTH words.
- `CLEAR_ON_RESET`, default 1: 1 runs the clear sequence after reset; 0 makes the array usable immediately.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mem_ctrl_input`  in  2  bit1 = mem_read, bit0 = mem_write.
- `address`  in  32  byte address.
- `w_data`  in  32  store data.
- `read_data`  out  32  load data, combinational.
- `init_busy`  out  1  high while the clear sequence runs.
- `mem_err`  out  1  one-cycle pulse, registered, flagging an illegal access in the previous cycle.
- `err_sticky`  out  1  set by the first illegal access; cleared only by reset.
- `err_addr`  out  32  address of the first illegal access since reset.

## Operation
- Word index is `address[ADDR_WIDTH+1:2]`.
- An access is *active* when `mem_ctrl_input != 2'b00`.
- An access is *legal* when all of these hold:
  - `address[1:0] == 0`
  - `address[31:ADDR_WIDTH+2] == 0`
  - state is READY
- State machine, two states:
  - **CLEAR**: `clr_idx` counts 0 → 2^ADDR_WIDTH−1. Each cycle writes 0 to `mem[clr_idx]`. After the write at the last index, go to READY.
  - **READY**: terminal state; serves pipeline accesses.
- Reset entry: reset drives state to CLEAR (or READY if `CLEAR_ON_RESET=0`) and `clr_idx` to 0.
- Legal write (bit0 = 1): `mem[idx] <= w_data` at the clock edge.
- Legal read (bit1 = 1): `read_data = mem[idx]`, showing pre-edge contents.
- `read_data = 0` in all of these cases:
  - bit1 = 0
  - the access is illegal
  - state is CLEAR
- `mem_ctrl_input == 2'b11`: treated as both read and write, and is not an error. `read_data` returns the old word; the new word is written at the edge.
- Illegal active access: the write is dropped. On the next edge `mem_err` is 1 for one cycle.
  - If `err_sticky` was 0, then `err_sticky <= 1` and `err_addr <= address`.
  - Later errors leave `err_addr` unchanged.
- Accesses during CLEAR count as illegal, with the same dropping and reporting.

## Timing
- Reset values:
  - `init_busy` = `CLEAR_ON_RESET`
  - `mem_err` = 0
  - `err_sticky` = 0
  - `err_addr` = 0
  - `read_data` = 0, because state is CLEAR or no request is present
- Array contents are not reset asynchronously.
- Clear latency is exactly 2^ADDR_WIDTH rising edges after reset deassertion. `init_busy` falls right after the edge that writes the last index.
- Reset asserted mid-clear: the sequence restarts from index 0 on release.
- Read latency 0 cycles; write latency 1 edge. A read of the same word in the cycle after a write returns the new data.
- `mem_err` latency is 1 edge after the offending cycle.
- There is no stall or handshake toward the pipeline. A hazard unit must hold the pipeline while `init_busy` is high.

## Structure
- Package `dmem_pkg`:
  - control-bit positions (`MEM_RD_BIT = 1`, `MEM_WR_BIT = 0`)
  - state enum {CLEAR, READY}
  - `WORD_BYTES = 4`
- Sub-module `dmem_array`:
  - 1 read port, combinational; 1 write port, synchronous
  - parameterised by ADDR_WIDTH; no reset
- Top level: write-port mux (clear sequencer vs. pipeline), legality check, error registers.

## Test plan
- ADDR_WIDTH = 4, reset pulse → `init_busy` high for exactly 16 edges after release, then low. A subsequent read of 0x00 → 0x00000000.
- Write 0xDEADBEEF to 0x10 (ctrl 2'b01), then read 0x10 (ctrl 2'b10) next cycle → `read_data` = 0xDEADBEEF and `mem_err` = 0.
- Write to 0x13 (misaligned) → no array change: a read of 0x10 still returns the prior value. `mem_err` pulses 1 cycle; `err_addr` = 0x13.
- Read 0x40 with ADDR_WIDTH = 4 (out of range) → `read_data` = 0 and `mem_err` pulses. `err_addr` stays at the first error, 0x13.
- Write 0x1 to 0x04 with ctrl 2'b11 → same-cycle `read_data` = old value; the next read returns 0x00000001.
- Reset asserted at clear index 7 → after release, `init_busy` lasts a full 16 edges. A write issued during busy is dropped and flagged.
